// File: rtl/tsr_pkg.sv
// tsr_pkg: shared state encoding, default geometry and width helpers for the
// tapped shift register feeder.
package tsr_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;
   localparam int DEF_DATA_WIDTH   = 8;
   localparam int DEF_BLOCK_LENGTH = 16;
   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with count-derived full/empty so any DEPTH works,
// including non-power-of-two depths.
module sync_fifo
   import tsr_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int DEPTH      = DEF_BLOCK_LENGTH,
   localparam int CW        = count_width(DEPTH),
   localparam int PW        = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  i_push,
   input  logic [DATA_WIDTH-1:0] i_data,
   input  logic                  i_pop,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic [CW-1:0]         o_count,
   output logic                  o_full,
   output logic                  o_empty
);
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  w_push, w_pop;

   assign o_full  = r_count == CW'(DEPTH);
   assign o_empty = r_count == '0;
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   always_ff @(posedge clk_in)
      if (w_push) r_mem[r_wr_ptr] <= i_data;

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr == PW'(DEPTH - 1) ? '0 : r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr == PW'(DEPTH - 1) ? '0 : r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end
endmodule

// File: rtl/block_serializer.sv
// block_serializer: buffers parallel words and streams them as one MSB-first
// serial frame per send, closing each frame with a one-cycle latch pulse.
module block_serializer
   import tsr_pkg::*;
#(
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int BLOCK_LENGTH = DEF_BLOCK_LENGTH,
   localparam int CW          = count_width(BLOCK_LENGTH),
   localparam int BW          = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic                  send,
   output logic                  ser_out,
   output logic                  ser_valid,
   output logic                  latch_out,
   output logic                  idle,
   output logic [CW-1:0]         word_count
);
   state_t                r_state, w_next;
   logic [DATA_WIDTH-1:0] r_shift, w_head;
   logic [BW-1:0]         r_bits;
   logic [CW-1:0]         r_words, w_count_next;
   logic                  w_push, w_pop, w_full, w_empty, w_last_bit;

   sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(BLOCK_LENGTH)) u_fifo (
      .clk_in  (clk_in),
      .rst_in  (rst_in),
      .i_push  (w_push),
      .i_data  (wr_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_count (word_count),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign idle         = r_state == IDLE;
   assign wr_ready     = idle && !w_full;
   assign w_push       = wr_valid && wr_ready;
   assign w_count_next = word_count + CW'(w_push);
   assign w_last_bit   = r_bits == '0;
   assign ser_valid    = r_state == SHIFT;
   assign ser_out      = ser_valid && r_shift[DATA_WIDTH-1];
   assign latch_out    = r_state == LATCH;

   always_ff @(posedge clk_in or posedge rst_in)
      if (rst_in) r_state <= IDLE;
      else        r_state <= w_next;

   // The next word is popped on the last bit of the current one, so words abut.
   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      case (r_state)
         IDLE:  if (send && (w_push || !w_empty)) w_next = LOAD;
         LOAD:  begin
            w_pop  = 1'b1;
            w_next = SHIFT;
         end
         SHIFT: if (w_last_bit) begin
            if (r_words == '0) w_next = LATCH;
            else               w_pop  = 1'b1;
         end
         LATCH: w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_shift <= '0;
         r_bits  <= '0;
         r_words <= '0;
      end else begin
         if (idle && w_next == LOAD) r_words <= w_count_next;
         if (w_pop) begin
            r_shift <= w_head;
            r_bits  <= BW'(DATA_WIDTH - 1);
            r_words <= r_words - 1'b1;
         end else if (ser_valid && !w_last_bit) begin
            r_shift <= r_shift << 1;
            r_bits  <= r_bits - 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_block_serializer.sv
// tb_block_serializer: directed stimulus with a bit-level scoreboard; expected
// bits are queued at send time and popped as ser_valid strobes arrive.
module tb_block_serializer;
   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic [7:0] wr_data = '0;
   logic       wr_valid = 1'b0;
   logic       send = 1'b0;
   logic       wr_ready, ser_out, ser_valid, latch_out, idle;
   logic [4:0] word_count;

   int   errors = 0;
   int   checks = 0;
   int   latch_cnt = 0;
   int   exp_latch = 0;
   logic exp_q [$];
   logic [7:0] mdl [$];

   block_serializer dut (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .wr_data    (wr_data),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .send       (send),
      .ser_out    (ser_out),
      .ser_valid  (ser_valid),
      .latch_out  (latch_out),
      .idle       (idle),
      .word_count (word_count)
   );

   always #5 clk_in = ~clk_in;

   always @(negedge clk_in) begin
      if (latch_out) latch_cnt++;
      checks++;
      if (ser_valid) begin
         if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL extra_bit: ser_valid=1 observed, no bit expected");
         end else begin
            logic eb;
            eb = exp_q.pop_front();
            assert (ser_out === eb) else begin
               errors++;
               $error("FAIL ser_bit: observed %b expected %b", ser_out, eb);
            end
         end
      end else begin
         assert (ser_out === 1'b0) else begin
            errors++;
            $error("FAIL ser_out_idle: observed %b expected 0", ser_out);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   task automatic wr(input logic [7:0] d);
      wr_data  = d;
      wr_valid = 1'b1;
      chk("wr_ready", wr_ready, mdl.size() < 16);
      if (mdl.size() < 16) mdl.push_back(d);
      step();
      wr_valid = 1'b0;
   endtask

   task automatic queue_frame();
      if (mdl.size() > 0) begin
         foreach (mdl[w]) for (int b = 7; b >= 0; b--) exp_q.push_back(mdl[w][b]);
         mdl.delete();
         exp_latch++;
      end
   endtask

   task automatic snd(input logic with_wr = 1'b0, input logic [7:0] d = '0);
      wr_data  = d;
      wr_valid = with_wr;
      send     = 1'b1;
      if (with_wr && mdl.size() < 16) mdl.push_back(d);
      queue_frame();
      step();
      send     = 1'b0;
      wr_valid = 1'b0;
   endtask

   task automatic wait_frame(input string tag);
      int n;
      n = 0;
      while (!(idle && exp_q.size() == 0) && n < 400) begin
         step();
         n++;
      end
      chk({tag, "_done"}, {31'd0, idle && exp_q.size() == 0}, 32'd1);
      chk({tag, "_latches"}, latch_cnt, exp_latch);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] a5;
      a5 = 8'hA5;
      step(2);
      chk("rst_idle", idle, 1);
      chk("rst_ready", wr_ready, 1);
      chk("rst_wc", word_count, 0);
      chk("rst_valid", ser_valid, 0);
      chk("rst_latch", latch_out, 0);
      rst_in = 1'b0;
      step();

      // 1: single word, exact cycle timing
      wr(8'hA5);
      snd();
      chk("t1_load_idle", idle, 0);
      chk("t1_load_valid", ser_valid, 0);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("t1_valid", ser_valid, 1);
         chk("t1_bit", ser_out, a5[7-i]);
      end
      step();
      chk("t1_latch", latch_out, 1);
      chk("t1_latch_valid", ser_valid, 0);
      step();
      chk("t1_idle", idle, 1);
      wait_frame("t1");

      // 2: three words, word_count steps at loads
      wr(8'h01); wr(8'h80); wr(8'hFF);
      snd();
      chk("t2_wc3", word_count, 3);
      step();
      chk("t2_wc2", word_count, 2);
      step(8);
      chk("t2_wc1", word_count, 1);
      step(8);
      chk("t2_wc0", word_count, 0);
      wait_frame("t2");

      // 3: fill to capacity, overflow write refused
      for (int i = 0; i < 16; i++) wr(8'(i));
      chk("t3_full_ready", wr_ready, 0);
      chk("t3_wc16", word_count, 16);
      wr(8'h55);
      chk("t3_wc_after", word_count, 16);
      snd();
      wait_frame("t3");

      // 4: empty send ignored; send with same-cycle write
      snd();
      step(4);
      chk("t4_idle", idle, 1);
      chk("t4_latches", latch_cnt, exp_latch);
      snd(1'b1, 8'h3C);
      wait_frame("t4");

      // 5: send and write during SHIFT ignored
      wr(8'hC3); wr(8'h96);
      snd();
      step(5);
      wr_data  = 8'hEE;
      wr_valid = 1'b1;
      send     = 1'b1;
      chk("t5_ready", wr_ready, 0);
      step();
      wr_valid = 1'b0;
      send     = 1'b0;
      wait_frame("t5");
      chk("t5_wc", word_count, 0);
      step(5);
      chk("t5_no_extra", latch_cnt, exp_latch);

      // 6: async reset mid-frame
      wr(8'h12); wr(8'h34); wr(8'h56); wr(8'h78);
      snd();
      step(12);
      #2 rst_in = 1'b1;
      #1;
      exp_q.delete();
      mdl.delete();
      exp_latch--;
      chk("t6_valid", ser_valid, 0);
      chk("t6_out", ser_out, 0);
      chk("t6_latch", latch_out, 0);
      chk("t6_idle", idle, 1);
      chk("t6_wc", word_count, 0);
      chk("t6_ready", wr_ready, 1);
      step(2);
      rst_in = 1'b0;
      step(3);
      chk("t6_no_latch", latch_cnt, exp_latch);
      wr(8'h5A);
      snd();
      wait_frame("t6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
